// File: rtl/function_unit_seq.sv
// Sequential 8-bit function unit: single-cycle logic/arith ops, iterative shifts
// and shift-add multiply, with a one-cycle register-file write strobe.
module function_unit_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [2:0] OP,
  input  logic [7:0] DATA_A,
  input  logic [7:0] DATA_B,
  input  logic [2:0] DR_IN,
  output logic       BUSY,
  output logic [7:0] D_OUT,
  output logic [2:0] DR,
  output logic       LD,
  output logic       C,
  output logic       Z,
  output logic       N
);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SHL = 3'b101,
                         OP_SHR = 3'b110, OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  typedef struct packed {
    logic [7:0] d;
    logic       c;
  } res_t;

  state_t      state;
  logic [2:0]  op_r, dr_r;
  logic [15:0] a_r, a_n, p_r, p_n;
  logic [7:0]  b_r, b_n;
  logic        c_r, c_n;
  logic [3:0]  cnt, k_in;
  res_t        q, it;

  // Iteration count chosen from the live inputs at acceptance.
  always_comb begin
    k_in = 4'd0;
    if (OP == OP_MUL)                         k_in = 4'd8;
    else if (OP == OP_SHL || OP == OP_SHR)    k_in = {1'b0, DATA_B[2:0]};
  end

  // Zero-iteration result, registered straight from the operand buses.
  always_comb begin
    q = '{d: DATA_A, c: 1'b0};
    case (OP)
      OP_ADD: {q.c, q.d} = {1'b0, DATA_A} + {1'b0, DATA_B};
      OP_SUB: {q.c, q.d} = {1'b0, DATA_A} - {1'b0, DATA_B};
      OP_AND: q.d = DATA_A & DATA_B;
      OP_OR:  q.d = DATA_A | DATA_B;
      OP_XOR: q.d = DATA_A ^ DATA_B;
      default: ;
    endcase
  end

  // One EXEC step; 'it' is the result if this step is the last.
  always_comb begin
    a_n = a_r;
    b_n = b_r;
    p_n = p_r;
    c_n = c_r;
    case (op_r)
      OP_SHL: begin a_n = {8'h00, a_r[6:0], 1'b0}; c_n = a_r[7]; end
      OP_SHR: begin a_n = {8'h00, 1'b0, a_r[7:1]}; c_n = a_r[0]; end
      OP_MUL: begin
        p_n = p_r + (b_r[0] ? a_r : 16'h0000);
        a_n = {a_r[14:0], 1'b0};
        b_n = {1'b0, b_r[7:1]};
      end
      default: ;
    endcase
    if (op_r == OP_MUL) it = '{d: p_n[7:0], c: |p_n[15:8]};
    else                it = '{d: a_n[7:0], c: c_n};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      LD    <= 1'b0;
      D_OUT <= 8'h00;
      DR    <= 3'd0;
      C     <= 1'b0;
      Z     <= 1'b0;
      N     <= 1'b0;
      op_r  <= 3'd0;
      dr_r  <= 3'd0;
      a_r   <= 16'h0000;
      b_r   <= 8'h00;
      p_r   <= 16'h0000;
      c_r   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      LD <= 1'b0;
      case (state)
        IDLE: if (START) begin
          op_r <= OP;
          dr_r <= DR_IN;
          a_r  <= {8'h00, DATA_A};
          b_r  <= DATA_B;
          p_r  <= 16'h0000;
          c_r  <= 1'b0;
          cnt  <= k_in;
          BUSY <= 1'b1;
          if (k_in == 4'd0) begin
            state <= WB;
            LD    <= 1'b1;
            D_OUT <= q.d;
            DR    <= DR_IN;
            C     <= q.c;
            Z     <= (q.d == 8'h00);
            N     <= q.d[7];
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          a_r <= a_n;
          b_r <= b_n;
          p_r <= p_n;
          c_r <= c_n;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= WB;
            LD    <= 1'b1;
            D_OUT <= it.d;
            DR    <= dr_r;
            C     <= it.c;
            Z     <= (it.d == 8'h00);
            N     <= it.d[7];
          end
        end
        WB: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_function_unit_seq.sv
// Directed bench for function_unit_seq: latency, LD pulse, flags, reset abort.
module tb_function_unit_seq;
  logic       CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic [2:0] OP = 3'd0, DR_IN = 3'd0;
  logic [7:0] DATA_A = 8'h00, DATA_B = 8'h00;
  logic       BUSY, LD, C, Z, N;
  logic [7:0] D_OUT;
  logic [2:0] DR;
  int total = 0, bad = 0;

  function_unit_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .DATA_A(DATA_A),
    .DATA_B(DATA_B), .DR_IN(DR_IN), .BUSY(BUSY), .D_OUT(D_OUT), .DR(DR),
    .LD(LD), .C(C), .Z(Z), .N(N)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, watch 14 cycles, check LD timing/count, BUSY span and results.
  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [2:0] dr, input int lat,
                     input logic [7:0] ed, input logic ec, input bit pulse_wb);
    int ld_cyc = 0, ld_cnt = 0, busy_cnt = 0;
    logic [13:0] cap = '0;
    OP = op; DATA_A = a; DATA_B = b; DR_IN = dr; START = 1'b1;
    tick();
    START = 1'b0; DATA_A = ~a; DATA_B = ~b; DR_IN = ~dr;
    for (int n = 1; n <= 14; n++) begin
      if (LD) begin
        ld_cnt++;
        if (ld_cyc == 0) begin ld_cyc = n; cap = {D_OUT, DR, C, Z, N}; end
      end
      if (BUSY) busy_cnt++;
      START = (pulse_wb && n == lat);
      tick();
    end
    START = 1'b0;
    chk({tag, " ld_cycle"}, ld_cyc, lat);
    chk({tag, " ld_count"}, ld_cnt, 1);
    chk({tag, " busy_cycles"}, busy_cnt, lat);
    chk({tag, " result"}, cap, {ed, dr, ec, ed == 8'h00, ed[7]});
    chk({tag, " hold"}, {D_OUT, C}, {ed, ec});
  endtask

  initial begin
    int ld_seen;
    RST = 1'b1;
    tick(); tick();
    chk("reset_outputs", {BUSY, LD, D_OUT, DR, C, Z, N}, 0);
    RST = 1'b0;
    tick();

    run("add_carry", 3'b000, 8'hF0, 8'h20, 3'd5, 1, 8'h10, 1'b1, 0);
    run("add_neg",   3'b000, 8'h7F, 8'h01, 3'd1, 1, 8'h80, 1'b0, 0);
    run("sub_borrow",3'b001, 8'h05, 8'h07, 3'd2, 1, 8'hFE, 1'b1, 0);
    run("and_zero",  3'b010, 8'hF0, 8'h0F, 3'd3, 1, 8'h00, 1'b0, 0);
    run("or",        3'b011, 8'h80, 8'h01, 3'd4, 1, 8'h81, 1'b0, 0);
    run("xor",       3'b100, 8'h3C, 8'hFF, 3'd6, 1, 8'hC3, 1'b0, 0);
    run("shl3",      3'b101, 8'h81, 8'h03, 3'd7, 4, 8'h08, 1'b0, 0);
    run("shl7",      3'b101, 8'h81, 8'h0F, 3'd0, 8, 8'h80, 1'b0, 0);
    run("shr1",      3'b110, 8'h81, 8'h01, 3'd2, 2, 8'h40, 1'b1, 0);
    run("shr0_wbpulse", 3'b110, 8'h9C, 8'h00, 3'd3, 1, 8'h9C, 1'b0, 1);
    run("mul",       3'b111, 8'h10, 8'h11, 3'd1, 9, 8'h10, 1'b1, 0);
    run("mul_zero",  3'b111, 8'h00, 8'h11, 3'd5, 9, 8'h00, 1'b0, 0);
    run("mul_small", 3'b111, 8'h0D, 8'h0B, 3'd6, 9, 8'h8F, 1'b0, 0);

    // Abort a multiply with reset at edge t+4, then start at t+5.
    OP = 3'b111; DATA_A = 8'h10; DATA_B = 8'h11; DR_IN = 3'd4; START = 1'b1;
    tick();
    START = 1'b0;
    ld_seen = 0;
    for (int n = 1; n <= 3; n++) begin
      if (LD) ld_seen++;
      tick();
    end
    RST = 1'b1;
    tick();
    chk("abort_no_early_ld", ld_seen, 0);
    chk("abort_outputs", {BUSY, LD, D_OUT, DR, C, Z, N}, 0);
    RST = 1'b0;
    run("after_abort", 3'b000, 8'h12, 8'h34, 3'd2, 1, 8'h46, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
